// File: rtl/mwmr_fifo.sv
// Multi-write/multi-read circular FIFO: up to WRITE pushes and READ pops per cycle, 1-cycle write-to-read latency.
// No backpressure stall: write lanes beyond the free space are dropped (wack low) and flagged in sticky ovf.
`ifndef LOW
`define LOW 1'b0
`endif
`ifndef HIGH
`define HIGH 1'b1
`endif

module mwmr_fifo #(
    parameter int DATA  = 64,
    parameter int DEPTH = 32,
    parameter int READ  = 4,
    parameter int WRITE = 4,
    parameter bit ACT   = `LOW,
    parameter int AFULL = DEPTH - WRITE
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush,
    input  logic [WRITE-1:0]                   we,
    input  logic [WRITE-1:0][DATA-1:0]         wd,
    output logic [WRITE-1:0]                   wack,
    input  logic [READ-1:0]                    re,
    output logic [READ-1:0][DATA-1:0]          rd,
    output logic [READ-1:0]                    v,
    output logic [$clog2(DEPTH+1)-1:0]         count,
    output logic                               busy,
    output logic                               afull,
    output logic                               ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA-1:0]  mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    waddr [WRITE];
    logic [WRITE-1:0] we_act;
    logic [READ-1:0]  re_act;
    logic [CW-1:0]    free;
    logic [CW-1:0]    wnum_acc;
    logic [CW-1:0]    rnum;
    logic             wrej;
    int               nreq;

    // Enabled lanes are packed in ascending order onto tail, tail+1, ...
    // Free space comes from the registered count only; same-cycle pops give no credit.
    always_comb begin
        we_act   = ACT ? we : ~we;
        free     = CW'(DEPTH) - count;
        wnum_acc = '0;
        wrej     = 1'b0;
        nreq     = 0;
        for (int j = 0; j < WRITE; j++) begin
            wack[j]  = 1'b0;
            waddr[j] = tail + PW'(nreq);
            if (we_act[j]) begin
                if (!flush && !reset && nreq < int'(free)) begin
                    wack[j]  = 1'b1;
                    wnum_acc = wnum_acc + CW'(1);
                end else if (!flush) begin
                    wrej = 1'b1;
                end
                nreq++;
            end
        end
    end

    // Pops always take the oldest entries; which lanes asserted re does not matter.
    always_comb begin
        re_act = ACT ? re : ~re;
        rnum   = '0;
        for (int i = 0; i < READ; i++) begin
            v[i]  = int'(count) > i;
            rd[i] = mem[head + PW'(i)];
            if (re_act[i] && v[i]) begin
                rnum = rnum + CW'(1);
            end
        end
        busy  = int'(count) > (DEPTH - WRITE);
        afull = int'(count) >= AFULL;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            head  <= head + PW'(rnum);
            tail  <= tail + PW'(wnum_acc);
            count <= count - rnum + wnum_acc;
            if (wrej) begin
                ovf <= 1'b1;
            end
            for (int j = 0; j < WRITE; j++) begin
                if (wack[j]) begin
                    mem[waddr[j]] <= wd[j];
                end
            end
        end
    end

endmodule

// File: tb/tb_mwmr_fifo.sv
// Scoreboard bench for mwmr_fifo with DEPTH=8, READ=2, WRITE=2, active-high enables, AFULL=6.
`ifndef LOW
`define LOW 1'b0
`endif
`ifndef HIGH
`define HIGH 1'b1
`endif

module tb_mwmr_fifo;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic [1:0]       we;
    logic [1:0][15:0] wd;
    logic [1:0]       wack;
    logic [1:0]       re;
    logic [1:0][15:0] rd;
    logic [1:0]       v;
    logic [3:0]       count;
    logic             busy;
    logic             afull;
    logic             ovf;

    int               checks = 0;
    int               errors = 0;
    logic [15:0]      q[$];
    logic             m_ovf = 1'b0;
    logic [1:0]       ow;
    logic [1:0]       ew;

    mwmr_fifo #(
        .DATA(16), .DEPTH(8), .READ(2), .WRITE(2), .ACT(`HIGH), .AFULL(6)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .we(we), .wd(wd), .wack(wack),
        .re(re), .rd(rd), .v(v), .count(count), .busy(busy), .afull(afull), .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // One cycle of stimulus; the model decides acceptance from its own occupancy.
    task automatic drive(input logic [1:0] w, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] r, output logic [1:0] o_w, output logic [1:0] e_w);
        int n, k, rn;
        logic [15:0] acc[$];
        @(negedge clk);
        we = w; wd[0] = a; wd[1] = b; re = r;
        #1 o_w = wack;
        n = q.size(); k = 0; rn = 0; e_w = '0;
        for (int j = 0; j < 2; j++) begin
            if (w[j]) begin
                if (k < 8 - n) begin
                    e_w[j] = 1'b1;
                    acc.push_back(j == 0 ? a : b);
                end else begin
                    m_ovf = 1'b1;
                end
                k++;
            end
        end
        for (int i = 0; i < 2; i++) if (r[i] && n > i) rn++;
        repeat (rn) void'(q.pop_front());
        foreach (acc[i]) q.push_back(acc[i]);
        @(posedge clk); #1;
        we = '0; re = '0;
    endtask

    task automatic test_reset;
        reset = 1'b1; flush = 1'b0; re = '0;
        we = 2'b11; wd[0] = 16'h1111; wd[1] = 16'h2222;
        #3;
        checks++; if (wack !== 2'b00) begin errors++; $display("FAIL reset_wack got %b exp 00", wack); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (v !== 2'b00) begin errors++; $display("FAIL reset_v got %b exp 00", v); end
        checks++; if ({ovf, busy, afull} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {ovf, busy, afull}); end
        checks++; if (rd !== '0) begin errors++; $display("FAIL reset_rd got %h exp 0", rd); end
        @(negedge clk); reset = 1'b0; we = '0;
    endtask

    task automatic test_basic;
        drive(2'b11, 16'h000A, 16'h000B, 2'b00, ow, ew);
        checks++; if (ow !== ew) begin errors++; $display("FAIL basic_wack got %b exp %b", ow, ew); end
        checks++; if (rd[0] !== 16'h000A) begin errors++; $display("FAIL basic_rd0 got %h exp 000a", rd[0]); end
        checks++; if (rd[1] !== 16'h000B) begin errors++; $display("FAIL basic_rd1 got %h exp 000b", rd[1]); end
        checks++; if (v !== 2'b11 || count !== 4'd2) begin errors++; $display("FAIL basic_state got v=%b count=%0d exp v=11 count=2", v, count); end
        drive(2'b00, 16'h0, 16'h0, 2'b11, ow, ew);
        checks++; if (count !== 4'(q.size())) begin errors++; $display("FAIL basic_drain got %0d exp %0d", count, q.size()); end
    endtask

    task automatic test_full;
        drive(2'b11, 16'd1, 16'd2, 2'b00, ow, ew);
        drive(2'b11, 16'd3, 16'd4, 2'b00, ow, ew);
        checks++; if (afull !== 1'b0 || count !== 4'd4) begin errors++; $display("FAIL full_at4 got afull=%b count=%0d exp afull=0 count=4", afull, count); end
        drive(2'b11, 16'd5, 16'd6, 2'b00, ow, ew);
        checks++; if ({busy, afull} !== 2'b01) begin errors++; $display("FAIL full_at6 got busy/afull=%b exp 01", {busy, afull}); end
        drive(2'b01, 16'd7, 16'd0, 2'b00, ow, ew);
        checks++; if (busy !== 1'b1 || ovf !== 1'b0 || count !== 4'd7) begin errors++; $display("FAIL full_at7 got busy=%b ovf=%b count=%0d exp 1 0 7", busy, ovf, count); end
        drive(2'b11, 16'd8, 16'd9, 2'b00, ow, ew);
        checks++; if (ow !== ew || ow !== 2'b01) begin errors++; $display("FAIL full_wack got %b exp %b", ow, ew); end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count got %0d exp 8", count); end
        checks++; if ({ovf, busy, afull} !== {m_ovf, 2'b11}) begin errors++; $display("FAIL full_flags got %b exp %b11", {ovf, busy, afull}, m_ovf); end
    endtask

    task automatic test_simul;
        drive(2'b11, 16'd10, 16'd11, 2'b11, ow, ew);
        checks++; if (ow !== ew) begin errors++; $display("FAIL simul_wack got %b exp %b", ow, ew); end
        checks++; if (count !== 4'd6) begin errors++; $display("FAIL simul_count got %0d exp 6", count); end
        checks++; if (rd[0] !== 16'd3 || rd[0] !== q[0]) begin errors++; $display("FAIL simul_rd0 got %0d exp 3", rd[0]); end
        checks++; if (rd[1] !== 16'd4 || rd[1] !== q[1]) begin errors++; $display("FAIL simul_rd1 got %0d exp 4", rd[1]); end
        drive(2'b00, 16'd0, 16'd0, 2'b11, ow, ew);
        checks++; if (count !== 4'd4) begin errors++; $display("FAIL simul_drain got %0d exp 4", count); end
    endtask

    task automatic test_flush;
        @(negedge clk);
        flush = 1'b1; we = 2'b11; wd[0] = 16'hF0; wd[1] = 16'hF1;
        #1;
        checks++; if (wack !== 2'b00) begin errors++; $display("FAIL flush_wack got %b exp 00", wack); end
        @(posedge clk); #1;
        flush = 1'b0; we = '0;
        q.delete(); m_ovf = 1'b0;
        checks++; if (count !== 4'd0 || v !== 2'b00) begin errors++; $display("FAIL flush_state got count=%0d v=%b exp 0 00", count, v); end
        checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL flush_ovf got %b exp %b", ovf, m_ovf); end
    endtask

    task automatic test_lane;
        drive(2'b01, 16'h21, 16'h0, 2'b00, ow, ew);
        drive(2'b00, 16'h0, 16'h0, 2'b10, ow, ew);
        checks++; if (count !== 4'd1 || rd[0] !== 16'h21) begin errors++; $display("FAIL lane_ignore got count=%0d rd0=%h exp 1 21", count, rd[0]); end
        drive(2'b01, 16'h22, 16'h0, 2'b00, ow, ew);
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL lane_fill got %0d exp 2", count); end
        drive(2'b00, 16'h0, 16'h0, 2'b10, ow, ew);
        checks++; if (count !== 4'd1 || rd[0] !== 16'h22 || rd[0] !== q[0]) begin errors++; $display("FAIL lane_pop got count=%0d rd0=%h exp 1 22", count, rd[0]); end
        drive(2'b00, 16'h0, 16'h0, 2'b11, ow, ew);
    endtask

    task automatic test_wrap;
        int nxt = 0;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (v[i]) begin
                    checks++;
                    if (rd[i] !== 16'(nxt)) begin errors++; $display("FAIL wrap_data got %0d exp %0d", rd[i], nxt); end
                    nxt++;
                end
            end
            if (c < 10) drive(2'b11, 16'(2*c), 16'(2*c+1), 2'b11, ow, ew);
            else        drive(2'b00, 16'h0, 16'h0, 2'b11, ow, ew);
            checks++; if (ow !== ew || count !== 4'(q.size())) begin errors++; $display("FAIL wrap_cycle got wack=%b count=%0d exp %b %0d", ow, count, ew, q.size()); end
        end
        checks++; if (nxt !== 20) begin errors++; $display("FAIL wrap_total got %0d exp 20", nxt); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL wrap_ovf got %b exp 0", ovf); end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 5; i++) drive(2'b11, 16'(16'h40 + 2*i), 16'(16'h41 + 2*i), 2'b00, ow, ew);
        drive(2'b00, 16'h0, 16'h0, 2'b11, ow, ew);
        drive(2'b00, 16'h0, 16'h0, 2'b01, ow, ew);
        checks++; if (count !== 4'd5 || ovf !== 1'b1) begin errors++; $display("FAIL areset_pre got count=%0d ovf=%b exp 5 1", count, ovf); end
        #2;
        reset = 1'b1; we = 2'b11;
        #1;
        checks++; if (count !== 4'd0 || v !== 2'b00 || ovf !== 1'b0) begin errors++; $display("FAIL areset_state got count=%0d v=%b ovf=%b exp 0 00 0", count, v, ovf); end
        checks++; if (wack !== 2'b00 || rd !== '0) begin errors++; $display("FAIL areset_out got wack=%b rd=%h exp 00 0", wack, rd); end
        @(negedge clk);
        reset = 1'b0; we = '0;
        q.delete(); m_ovf = 1'b0;
        drive(2'b11, 16'h55, 16'h66, 2'b00, ow, ew);
        checks++; if (count !== 4'd2 || rd[0] !== 16'h55 || rd[1] !== 16'h66) begin errors++; $display("FAIL areset_after got count=%0d rd=%h exp 2 0066_0055", count, rd); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_simul();
        test_flush();
        test_lane();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mwmr_fifo.md
MWMR_FIFO -- requirements
Module: mwmr_fifo

Interface
REQ-001 The block SHALL have parameter DATA, default 64: width of one entry in bits.
REQ-002 The block SHALL have parameter DEPTH, default 32: number of entries, a power of two and at least max(READ,WRITE).
REQ-003 The block SHALL have parameter READ, default 4: number of read lanes.
REQ-004 The block SHALL have parameter WRITE, default 4: number of write lanes.
REQ-005 The block SHALL have parameter ACT, default `LOW: active polarity of we and re.
REQ-006 The block SHALL have parameter AFULL, default DEPTH-WRITE: afull threshold in entries, in the range 1..DEPTH.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 The block SHALL have port flush, input, 1 bit: synchronous active-high clear.
REQ-010 The block SHALL have port we, input, WRITE bits: per-lane write enable, polarity ACT.
REQ-011 The block SHALL have port wd, input, WRITE x DATA bits: per-lane write data.
REQ-012 The block SHALL have port wack, output, WRITE bits: lane write accepted this cycle, active high, combinational.
REQ-013 The block SHALL have port re, input, READ bits: per-lane read enable, polarity ACT.
REQ-014 The block SHALL have port rd, output, READ x DATA bits: rd[i] is the i-th oldest entry.
REQ-015 The block SHALL have port v, output, READ bits: rd[i] valid, active high; equals (count > i).
REQ-016 The block SHALL have port count, output, $clog2(DEPTH+1) bits: current occupancy.
REQ-017 The block SHALL have port busy, output, 1 bit: high when count > DEPTH-WRITE.
REQ-018 The block SHALL have port afull, output, 1 bit: high when count >= AFULL.
REQ-019 The block SHALL have port ovf, output, 1 bit: sticky flag, set when any enabled write lane is rejected.

Function
REQ-020 The block SHALL store entries in a circular buffer with head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH; entries SHALL NOT shift.
REQ-021 wnum_req SHALL be the number of enabled we lanes, and free SHALL be DEPTH-count, computed from registered count with no credit for same-cycle reads.
REQ-022 Enabled write lanes SHALL be compacted in ascending lane order; the k-th enabled lane (k from 0) SHALL be written to tail+k and have wack high only if k < free.
REQ-023 tail SHALL advance by wnum_acc, the number of wack bits set; rejected lanes SHALL be dropped, with no retry held internally.
REQ-024 rnum SHALL be popcount(re_active & v); the oldest rnum entries SHALL be consumed, independent of which lanes asserted re, and head SHALL advance by rnum.
REQ-025 re on an invalid lane SHALL be ignored; reading when empty SHALL leave all state unchanged.
REQ-026 The next count SHALL be count - rnum + wnum_acc; count SHALL never exceed DEPTH or underflow.
REQ-027 Latency SHALL be 1 cycle: data written at edge N SHALL appear on rd/v after edge N; there SHALL be no write-to-read bypass.
REQ-028 Simultaneous read and write in the same cycle, including at full or empty, SHALL be legal and obey REQ-021..026.
REQ-029 ovf SHALL be set at the edge after any cycle in which an enabled write lane has wack low, and SHALL be cleared only by reset or flush.
REQ-030 flush SHALL have priority over all reads and writes: in a flush cycle wack SHALL be 0, and at the next edge head, tail, count and ovf SHALL be 0.

Reset
REQ-031 While reset is high, head, tail, count and ovf SHALL be 0 and all storage entries SHALL be 0, immediately and without waiting for clk.
REQ-032 During reset, v, busy, afull, ovf and wack SHALL be 0 and rd SHALL be all zeros.
REQ-033 Reset asserted mid-burst SHALL discard all contents; the first edge after deassertion SHALL behave as writes into an empty buffer.

Verification
Scenarios use DEPTH=8, READ=2, WRITE=2, ACT=`HIGH, AFULL=6.
REQ-034 Write we=11 with wd={B,A} in one cycle -> next cycle rd[0]=A, rd[1]=B, v=11, count=2.
REQ-035 At count=7, write we=11 -> wack=01, count=8, ovf=1 next cycle, busy=1, afull=1.
REQ-036 At count=8, re=11 together with we=11 -> wack=00, count=6, and rd then shows entries 3 and 4 in oldest-first order.
REQ-037 Push 20 entries 0..19 while draining 2 per cycle -> output sequence 0..19 in order across pointer wrap, ovf=0.
REQ-038 At count=1, re=10 (lane 1 only) -> rnum=0 and no change; at count=2, re=10 -> oldest entry consumed, count=1.
REQ-039 Assert reset asynchronously mid-cycle with count=5 and ovf=1 -> count=0, v=00 and ovf=0 before the next clk edge; flush at count=4 with we=11 -> count=0, wack=00.
